mmio_ctrl: RTL

Parametrised memory-mapped data-side controller for the CPU top level, replacing the single fixed-width output register with three address-decoded regions. It holds a data RAM, N_OUT output channel registers and a loadable free-running cycle counter. It sits between the core's data port (addr/wdata/we) and the board outputs. Reads return registered data with a valid strobe; illegal accesses raise an error pulse.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_ram.sv | 25 ++
 rtl/mmio_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared region codes and access-decode result for the memory-mapped data-side controller.
package mmio_pkg;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_OUT = 4'h8;
    localparam logic [3:0] REG_CNT = 4'h9;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_OUT,
        ACC_CNT,
        ACC_ERR
    } acc_t;

endpackage

// File: rtl/mmio_ram.sv
// Single-port data RAM with synchronous, read-before-write read port. Contents are not reset.
module mmio_ram #(
    parameter int RAM_AW     = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [RAM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped data-side controller: data RAM, N_OUT output channel registers and a
// loadable free-running cycle counter, with a one-cycle read response and error pulse.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_AW     = 5,
    parameter int N_OUT      = 2,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       we,
    input  logic                       re,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rvalid,
    output logic                       err,
    output logic [N_OUT*OUT_WIDTH-1:0] data_out,
    output logic [N_OUT-1:0]           out_upd
);

    localparam int IDX_W = ADDR_WIDTH - 6;

    logic [3:0]            region;
    logic [IDX_W-1:0]      idx;
    acc_t                  acc;
    logic                  access;
    logic [DATA_WIDTH-1:0] ch_rd;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  vld_p1;
    logic                  err_p1;
    acc_t                  sel_p1;
    logic [DATA_WIDTH-1:0] rd_p1;
    logic [DATA_WIDTH-1:0] rd_hold;

    assign region = addr[ADDR_WIDTH-1 -: 4];
    assign idx    = addr[ADDR_WIDTH-5:2];
    assign access = we | re;

    // Stage p0: combinational address decode
    always_comb begin
        acc = ACC_ERR;
        if (addr[1:0] == 2'b00) begin
            case (region)
                REG_RAM: if ((idx >> RAM_AW) == '0) acc = ACC_RAM;
                REG_OUT: if (idx < IDX_W'(N_OUT))   acc = ACC_OUT;
                REG_CNT: if (idx == '0)             acc = ACC_CNT;
                default: acc = ACC_ERR;
            endcase
        end
    end

    always_comb begin
        ch_rd = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (idx[2:0] == 3'(k)) begin
                ch_rd[OUT_WIDTH-1:0] = data_out[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    mmio_ram #(
        .RAM_AW    (RAM_AW),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (access && (acc == ACC_RAM)),
        .we   (we && (acc == ACC_RAM)),
        .addr (idx[RAM_AW-1:0]),
        .wdata(wdata),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            out_upd  <= '0;
        end else begin
            out_upd <= '0;
            if (we && (acc == ACC_OUT)) begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (idx[2:0] == 3'(k)) begin
                        data_out[k*OUT_WIDTH +: OUT_WIDTH] <= wdata[OUT_WIDTH-1:0];
                        out_upd[k]                         <= 1'b1;
                    end
                end
            end
        end
    end

    // A load takes priority over the increment on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (we && (acc == ACC_CNT)) begin
            cnt <= wdata;
        end else begin
            cnt <= cnt + DATA_WIDTH'(1);
        end
    end

    // Stage p1: response register, region registered alongside the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            sel_p1  <= ACC_ERR;
            rd_hold <= '0;
        end else begin
            vld_p1  <= re && (acc != ACC_ERR);
            err_p1  <= access && (acc == ACC_ERR);
            sel_p1  <= acc;
            rd_hold <= rdata;
        end
    end

    // Counter and channel values are captured before this edge's write/increment.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_p1 <= (acc == ACC_CNT) ? cnt : ch_rd;
        end
    end

    assign rdata  = !vld_p1 ? rd_hold : ((sel_p1 == ACC_RAM) ? ram_q : rd_p1);
    assign rvalid = vld_p1;
    assign err    = err_p1;

endmodule
